// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and glyph lookup for the multi-digit
//                seven-segment scan driver. Glyphs are 7-bit {a,b,c,d,e,f,g},
//                active low; the full segment byte appends an active-low dp.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Number of PWM subslots per digit slot; subslot 0 is the dead time.
    localparam int SUBSLOTS = 16;

    // Decimal glyphs {a,b,c,d,e,f,g}, active low
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    // Hex glyphs A, b, C, d, E, F
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Shown for nibbles 10..15 when hex glyphs are disabled (an "8")
    localparam logic [6:0] SEG_HEX_FALLBACK = 7'b0000000;

    // All segments and the decimal point dark
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Nibble + decimal point to the active-low segment byte {a..g,dp}.
    function automatic logic [7:0] seg7_glyph(
        input logic [3:0] i_nibble,
        input logic       i_dp,
        input logic       i_hex_en
    );
        logic [6:0] w_g;
        case (i_nibble)
            4'h0:    w_g = SEG_0;
            4'h1:    w_g = SEG_1;
            4'h2:    w_g = SEG_2;
            4'h3:    w_g = SEG_3;
            4'h4:    w_g = SEG_4;
            4'h5:    w_g = SEG_5;
            4'h6:    w_g = SEG_6;
            4'h7:    w_g = SEG_7;
            4'h8:    w_g = SEG_8;
            4'h9:    w_g = SEG_9;
            4'hA:    w_g = SEG_A;
            4'hB:    w_g = SEG_B;
            4'hC:    w_g = SEG_C;
            4'hD:    w_g = SEG_D;
            4'hE:    w_g = SEG_E;
            default: w_g = SEG_F;
        endcase
        if (!i_hex_en && (i_nibble > 4'd9)) begin
            w_g = SEG_HEX_FALLBACK;
        end
        return {w_g, ~i_dp};
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_encode
//  Description : Combinational nibble + decimal point to active-low segment
//                byte {a,b,c,d,e,f,g,dp}.
//  Ports       : i_nibble [3:0] - digit value
//                i_dp           - decimal point, 1 = lit
//                o_seg_n  [7:0] - segment byte, active low
//  Parameters  : HEX_EN - 1: 10..15 show A..F, 0: they show "8"
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_encode
#(
    parameter bit HEX_EN = 1'b1
)
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg_n
);

    import seg7_pkg::*;

    assign o_seg_n = seg7_glyph(i_nibble, i_dp, HEX_EN);

endmodule : seg7_encode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for an N-digit common-anode seven-
//                segment display. A load strobe captures value, decimal
//                points, leading-zero blanking and brightness into shadow
//                registers; the scanner walks the digits one slot at a time.
//                Each slot is 16 PWM subslots of SUB_DIV clocks; subslot 0 is
//                a dead time, subslots 1..bright light the digit.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                load                 - one-cycle capture strobe
//                value [4N-1:0]       - packed nibbles, digit 0 rightmost
//                dp_in [N-1:0]        - decimal points, 1 = lit
//                lz_en                - leading-zero blanking enable
//                bright [3:0]         - brightness 0..15 (0 = dark)
//                seg_n [7:0]          - {a..g,dp}, active low, registered
//                an_n [N-1:0]         - anode enables, active low, registered
//                frame_tick           - one-cycle pulse per completed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
#(
    parameter int N_DIGITS = 4,
    parameter int SUB_DIV  = 3125,
    parameter bit HEX_EN   = 1'b1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    output logic [7:0]            seg_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_tick
);

    import seg7_pkg::*;

    localparam int c_SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int c_DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [c_SUB_W-1:0] c_SUB_LAST  = c_SUB_W'(SUB_DIV - 1);
    localparam logic [c_DIG_W-1:0] c_DIG_LAST  = c_DIG_W'(N_DIGITS - 1);
    localparam logic [3:0]         c_SLOT_LAST = 4'(SUBSLOTS - 1);

    // ------------------------------------------------------------------
    // Shadow registers: the scanner reads only these, never the inputs
    // ------------------------------------------------------------------
    logic [4*N_DIGITS-1:0] r_value;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_blank;
    logic [3:0]            r_bright;

    // ------------------------------------------------------------------
    // Scan counters and registered outputs
    // ------------------------------------------------------------------
    logic [c_SUB_W-1:0]    r_sub_cnt;
    logic [3:0]            r_subslot;
    logic [c_DIG_W-1:0]    r_digit;

    logic [7:0]            r_seg_n;
    logic [N_DIGITS-1:0]   r_an_n;
    logic                  r_frame_tick;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0]   w_blank_new;
    logic                  w_lz_run;
    logic                  w_sub_wrap;
    logic                  w_slot_wrap;
    logic                  w_frame_wrap;
    logic [3:0]            w_cur_nib;
    logic                  w_cur_dp;
    logic                  w_cur_blank;
    logic [N_DIGITS-1:0]   w_an_sel;
    logic [7:0]            w_glyph;
    logic                  w_lit;

    // Leading-zero mask, evaluated on the incoming load data. Walking down
    // from the most significant digit, blanking continues only while every
    // digit seen so far is a zero without a decimal point. Digit 0 is
    // outside the loop so a value of all zeros still shows a single "0".
    always_comb begin
        w_blank_new = '0;
        w_lz_run    = lz_en;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (w_lz_run && (value[4*i +: 4] == 4'h0) && !dp_in[i]) begin
                w_blank_new[i] = 1'b1;
            end else begin
                w_lz_run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value  <= '0;
            r_dp     <= '0;
            r_blank  <= '0;
            r_bright <= 4'hF;
        end else if (load) begin
            r_value  <= value;
            r_dp     <= dp_in;
            r_blank  <= w_blank_new;
            r_bright <= bright;
        end
    end

    // ------------------------------------------------------------------
    // Counter chain: sub_cnt -> subslot -> digit
    // ------------------------------------------------------------------
    assign w_sub_wrap   = (r_sub_cnt == c_SUB_LAST);
    assign w_slot_wrap  = w_sub_wrap && (r_subslot == c_SLOT_LAST);
    assign w_frame_wrap = w_slot_wrap && (r_digit == c_DIG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub_cnt <= '0;
            r_subslot <= '0;
            r_digit   <= '0;
        end else begin
            if (w_sub_wrap) begin
                r_sub_cnt <= '0;
                if (w_slot_wrap) begin
                    r_subslot <= '0;
                    if (w_frame_wrap) begin
                        r_digit <= '0;
                    end else begin
                        r_digit <= r_digit + c_DIG_W'(1);
                    end
                end else begin
                    r_subslot <= r_subslot + 4'd1;
                end
            end else begin
                r_sub_cnt <= r_sub_cnt + c_SUB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Current-digit selection; also builds the one-hot-low anode pattern
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_nib   = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        w_an_sel    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_digit == c_DIG_W'(i)) begin
                w_cur_nib   = r_value[4*i +: 4];
                w_cur_dp    = r_dp[i];
                w_cur_blank = r_blank[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    seg7_encode #(
        .HEX_EN   (HEX_EN)
    ) u_encode (
        .i_nibble (w_cur_nib),
        .i_dp     (w_cur_dp),
        .o_seg_n  (w_glyph)
    );

    // Lit during subslots 1..bright; subslot 0 is always dark so the
    // previous digit's segments never bleed into the next anode.
    assign w_lit = (r_subslot != 4'd0) && (r_subslot <= r_bright) && !w_cur_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n      <= SEG_BLANK;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg_n      <= w_lit ? w_glyph  : SEG_BLANK;
            r_an_n       <= w_lit ? w_an_sel : '1;
            r_frame_tick <= w_frame_wrap;
        end
    end

    assign seg_n      = r_seg_n;
    assign an_n       = r_an_n;
    assign frame_tick = r_frame_tick;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver (N=4, SUB_DIV=2).
//                Two instances share stimulus: one with hex glyphs, one
//                without. A reference model derives every output from the
//                elapsed cycle count since reset and the last captured load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int SUB   = 2;
    localparam int SLOT  = 16 * SUB;
    localparam int FRAME = SLOT * N;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] value  = '0;
    logic [3:0]  dp_in  = '0;
    logic        lz_en  = 1'b0;
    logic [3:0]  bright = '0;

    logic [7:0]  seg_hex, seg_nohex;
    logic [3:0]  an_hex, an_nohex;
    logic        ft_hex, ft_nohex;

    seg7_scan_driver #(.N_DIGITS(N), .SUB_DIV(SUB), .HEX_EN(1'b1)) u_dut_hex (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .lz_en(lz_en), .bright(bright), .seg_n(seg_hex), .an_n(an_hex),
        .frame_tick(ft_hex)
    );

    seg7_scan_driver #(.N_DIGITS(N), .SUB_DIV(SUB), .HEX_EN(1'b0)) u_dut_nohex (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .lz_en(lz_en), .bright(bright), .seg_n(seg_nohex), .an_n(an_nohex),
        .frame_tick(ft_nohex)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg_h;
        logic [7:0] seg_8;
        logic [3:0] an;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Glyph shapes {a..g}, active low, for nibbles 0..F
    logic [6:0] gly [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [7:0] ref_glyph(input int nib, input bit dp, input bit hex);
        if (!hex && nib >= 10) return {7'b0000000, ~dp};
        return {gly[nib], ~dp};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: p = clock edges since reset release
    // ------------------------------------------------------------------
    int m_p = 0;
    int m_nib [N];
    bit m_dp [N];
    bit m_blank [N];
    int m_bright = 15;

    initial begin
        forever begin
            exp_t e;
            int   d, ss, top;
            bit   lit;
            @(posedge clk);
            if (!rst_n) begin
                e = '{seg_h: 8'hFF, seg_8: 8'hFF, an: 4'hF, ft: 1'b0};
                m_p = 0;
                m_bright = 15;
                for (int i = 0; i < N; i++) begin
                    m_nib[i] = 0; m_dp[i] = 0; m_blank[i] = 0;
                end
            end else begin
                d   = (m_p / SLOT) % N;
                ss  = (m_p / SUB) % 16;
                lit = (ss >= 1) && (ss <= m_bright) && !m_blank[d];
                e.an    = lit ? ~(4'b0001 << d) : 4'hF;
                e.seg_h = lit ? ref_glyph(m_nib[d], m_dp[d], 1'b1) : 8'hFF;
                e.seg_8 = lit ? ref_glyph(m_nib[d], m_dp[d], 1'b0) : 8'hFF;
                e.ft    = ((m_p + 1) % FRAME) == 0;
                if (load) begin
                    top = 0;
                    for (int i = 0; i < N; i++) begin
                        m_nib[i] = int'(value[4*i +: 4]);
                        m_dp[i]  = dp_in[i];
                        if (m_nib[i] != 0 || m_dp[i]) top = i;
                    end
                    for (int i = 0; i < N; i++) m_blank[i] = lz_en && (i > top);
                    m_bright = int'(bright);
                end
                m_p++;
            end
            q.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: one expected entry per clock, compared on the falling edge
    // ------------------------------------------------------------------
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
            end else begin
                e = q.pop_front();
                if (seg_hex !== e.seg_h || seg_nohex !== e.seg_8 || an_hex !== e.an ||
                    an_nohex !== e.an || ft_hex !== e.ft || ft_nohex !== e.ft) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL scan at %0t: got seg=%b/%b an=%b/%b ft=%b/%b, expected seg=%b/%b an=%b ft=%b",
                                 $time, seg_hex, seg_nohex, an_hex, an_nohex, ft_hex, ft_nohex,
                                 e.seg_h, e.seg_8, e.an, e.ft);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; holds load for exactly one rising edge
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp,
                           input logic lz, input logic [3:0] br);
        value = v; dp_in = dp; lz_en = lz; bright = br; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic rand_fields();
        value  = 16'($urandom) >> (4 * $urandom_range(3, 0));
        dp_in  = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 0)) : 4'h0;
        lz_en  = 1'($urandom_range(1, 0));
        bright = 4'($urandom_range(15, 0));
    endtask

    initial begin
        int cnt;

        // Reset state
        idle(3);
        check("reset_seg", {24'h0, seg_hex}, 32'hFF);
        check("reset_an", {28'h0, an_hex}, 32'hF);
        check("reset_ft", {31'h0, ft_hex}, 32'h0);
        rst_n = 1'b1;

        // First lit anode appears SUB_DIV+1 edges after release
        cnt = 0;
        while (an_hex === 4'hF && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        check("first_anode_delay", cnt, SUB + 1);
        check("first_anode", {28'h0, an_hex}, 32'hE);
        @(negedge clk);

        // Directed patterns
        do_load(16'h0042, 4'b0000, 1'b1, 4'd15);
        idle(2 * FRAME);
        do_load(16'h00A0, 4'b0100, 1'b1, 4'd15);
        idle(FRAME);
        do_load(16'h3A07, 4'b0000, 1'b0, 4'd4);
        idle(FRAME);
        do_load(16'h0501, 4'b0010, 1'b1, 4'd0);
        idle(FRAME);

        // Randomised loads with random spacing, sometimes back-to-back
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(3, 0) == 0) begin
                rand_fields(); load = 1'b1;
                @(negedge clk);
                rand_fields();
                @(negedge clk);
                load = 1'b0;
            end else begin
                rand_fields(); load = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end
            idle($urandom_range(60, 0));
        end

        // Load inside the digit-0 lit window
        do_load(16'h1234, 4'b0000, 1'b0, 4'd15);
        cnt = 0;
        while (an_hex !== 4'b1110 && cnt < 2 * FRAME) begin
            @(negedge clk); cnt++;
        end
        check("digit0_window_found", {28'h0, an_hex}, 32'hE);
        idle(3);
        do_load(16'h567C, 4'b0001, 1'b0, 4'd15);
        idle(40);

        // Asynchronous reset mid-frame
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", {24'h0, seg_hex}, 32'hFF);
        check("async_rst_an", {28'h0, an_hex}, 32'hF);
        check("async_rst_ft", {31'h0, ft_hex}, 32'h0);
        check("async_rst_seg_nohex", {24'h0, seg_nohex}, 32'hFF);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        // Back-to-back loads, last wins: 8888 shown on every digit
        value = 16'h1111; dp_in = 4'hF; lz_en = 1'b1; bright = 4'd2; load = 1'b1;
        @(negedge clk);
        value = 16'h8888; dp_in = 4'h0; lz_en = 1'b0; bright = 4'd15;
        @(negedge clk);
        load = 1'b0;
        idle(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display with decimal points. It latches a packed multi-digit nibble value on a load strobe and scans one digit at a time with a programmable refresh rate. Per-digit brightness uses PWM with an anti-ghosting dead subslot, and leading-zero blanking is optional. It sits between the numeric datapath and the board's segment and anode pins, and generalises the single-digit segment coder to N digits with hex glyphs.

## Interface
- N_DIGITS, 4, number of digits scanned (2..8).
- SUB_DIV, 3125, clock cycles per PWM subslot; one digit slot = 16*SUB_DIV cycles.
- HEX_EN, 1, 1: nibbles 10..15 show A,b,C,d,E,F; 0: they show the "8" glyph.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures value, dp_in, lz_en, bright.
- value  in  4*N_DIGITS  packed nibbles; digit i = value[4i+3:4i], digit 0 rightmost.
- dp_in  in  N_DIGITS  per-digit decimal point, 1 = lit.
- lz_en  in  1  leading-zero blanking enable.
- bright  in  4  brightness 0..15; 0 = dark.
- seg_n  out  8  segments {a,b,c,d,e,f,g,dp}, active low.
- an_n  out  N_DIGITS  digit anode enables, active low, one-hot-or-none.
- frame_tick  out  1  one-cycle pulse at end of digit N_DIGITS-1 slot.

## Operation
- Shadow registers hold value, dp, blank mask and bright; the display uses only shadows. load updates all shadows in the same cycle; it is accepted every cycle with no backpressure.
- Blank mask is computed at load. With lz_en=1, scanning from digit N_DIGITS-1 downward, a digit is blanked while its nibble is 0 and its dp bit is 0. Digit 0 is never blanked. With lz_en=0 the mask is all zero.
- Glyphs (active low, dp bit = ~dp):
  - Digits 0..9: 0000001x, 1001111x, 0010010x, 0000110x, 1001100x, 0100100x, 0100000x, 0001111x, 0000000x, 0000100x.
  - A..F: 0001000x, 1100000x, 0110001x, 1000010x, 0110000x, 0111000x.
- Counters:
  - sub_cnt runs 0..SUB_DIV-1.
  - subslot runs 0..15, advancing when sub_cnt wraps.
  - digit runs 0..N_DIGITS-1, advancing when subslot wraps 15→0. Digit N_DIGITS-1 wraps to 0.
- Per-cycle outputs are registered:
  - an_n[digit]=0 only when 1 ≤ subslot ≤ bright and the digit is not blanked. All other an_n bits are 1.
  - seg_n shows the current digit's glyph whenever its anode is active, and 8'hFF otherwise.
- Subslot 0 of every slot is the dead time: all anodes off.
- frame_tick pulses in the cycle digit wraps N_DIGITS-1→0.

## Timing
- Reset state: seg_n=8'hFF, an_n=all 1, frame_tick=0. Counters are 0. Shadow value=0, dp=0, blank mask=0, bright=15.
- Outputs lag the counter state by one cycle.
- load→visible change takes 1 cycle, provided the current digit's anode is active in the following cycle.
- Slot = 16*SUB_DIV cycles; frame = N_DIGITS slots.
- Duty per digit = bright/16 of its slot.
- Simultaneous load and slot boundary: the new shadows apply to the new digit.
- A load during a digit slot does not restart the counters.
- rst_n asserted mid-frame: outputs go to the reset state immediately (asynchronously). Scanning restarts at digit 0, subslot 0 after release.
- bright=0: an_n stays all 1, seg_n stays 8'hFF. frame_tick still pulses.

## Structure
- Package seg7_pkg holds:
  - the 16 glyph constants SEG_0..SEG_F (7-bit, a..g, active low);
  - SEG_BLANK = 8'hFF;
  - the HEX-disabled fallback glyph;
  - function seg7_glyph(nibble, dp, hex_en).
- Sub-module seg7_encode: combinational nibble + dp → 8-bit seg_n, parameter HEX_EN. It is instantiated once, on the muxed current digit.
- Top level contains the shadow registers, blank-mask logic, the three counters, and the output registers.

## Test plan
- Reset: hold rst_n=0 → seg_n=8'hFF, an_n=4'b1111, frame_tick=0; release → first active anode is an_n=4'b1110 exactly SUB_DIV+1 cycles later.
- With SUB_DIV=2, load value=16'h0042, dp_in=0, lz_en=1, bright=15 → digit0 seg_n=8'b00100101, digit1 seg_n=8'b10011001, digits 2/3 never assert an_n; frame_tick period = 128 cycles.
- Load value=16'h00A0, dp_in=4'b0100, lz_en=1, HEX_EN=1 → digit2 shows 8'b00000010 (0 with dp), digit1 shows 8'b00010001, digit3 is blanked. Repeat with HEX_EN=0 → digit1 shows 8'b00000001.
- bright=4, SUB_DIV=2 → each digit's anode is low for exactly 8 cycles per 32-cycle slot, during subslots 1..4; bright=0 → no anode is ever low.
- Load a new value in the middle of the digit0 active window → seg_n changes 1 cycle after load with no counter reset; then assert rst_n=0 mid-frame → outputs go immediately to 8'hFF / all 1.
- Back-to-back load strobes on consecutive cycles → the last value wins; value=16'h8888 with lz_en=0 shows 8'b00000001 on all digits.
